// File: rtl/mmm_in_parser.sv
// Host word stream parser: maxsize word, then per problem a vertex word and its adjacency words; writes matrix words one cycle after accept.
// Header valid one cycle after entering hold; want is state-decoded, so the host stalls in calc/hold and the engine stalls via i_prob_accept.
module mmm_in_parser #(
    parameter int MAX_VERTSBITS = 6,
    parameter int AW            = 2*MAX_VERTSBITS-4
) (
    input  logic                     i_clk150,
    input  logic                     i_reset,
    input  logic [31:0]              i_indata,
    input  logic                     i_indata_have,
    output logic                     o_indata_want,
    output logic [15:0]              o_init_maxsize,
    output logic                     o_init_valid,
    output logic                     o_mat_we,
    output logic [AW-1:0]            o_mat_addr,
    output logic [31:0]              o_mat_wdata,
    output logic                     o_prob_valid,
    input  logic                     i_prob_accept,
    output logic [MAX_VERTSBITS-1:0] o_prob_nverts,
    output logic                     o_prob_last,
    output logic [15:0]              o_prob_id,
    output logic                     o_overflow
);
    localparam int NW = 2*MAX_VERTSBITS+1;

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_NVERTS = 3'd1;
    localparam logic [2:0] S_CALC   = 3'd2;
    localparam logic [2:0] S_MATRIX = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [15:0]              maxsize_q, maxsize_d;
    logic                     init_vld_q, init_vld_d;
    logic [MAX_VERTSBITS-1:0] nverts_q, nverts_d;
    logic                     last_q, last_d;
    logic [15:0]              prob_id_q, prob_id_d;
    logic                     overflow_q, overflow_d;
    logic [NW-1:0]            n_words_q, n_words_d;
    logic [AW-1:0]            word_cnt_q, word_cnt_d;
    logic                     mat_we_q, mat_we_d;
    logic [AW-1:0]            mat_addr_q, mat_addr_d;
    logic [31:0]              mat_wdata_q, mat_wdata_d;
    logic                     prob_vld_q, prob_vld_d;

    logic                     accept;
    logic [NW-1:0]            nn_sum;
    logic [NW-1:0]            n_words_calc;

    assign o_indata_want = (state_q == S_INIT) || (state_q == S_NVERTS) || (state_q == S_MATRIX);
    assign accept        = o_indata_want && i_indata_have;

    // Full-width square so n*n+31 cannot wrap before the divide by 32.
    assign nn_sum       = NW'(nverts_q) * NW'(nverts_q) + NW'(31);
    assign n_words_calc = nn_sum >> 5;

    always_comb begin
        state_d     = state_q;
        maxsize_d   = maxsize_q;
        init_vld_d  = 1'b0;
        nverts_d    = nverts_q;
        last_d      = last_q;
        prob_id_d   = prob_id_q;
        overflow_d  = overflow_q;
        n_words_d   = n_words_q;
        word_cnt_d  = word_cnt_q;
        mat_we_d    = 1'b0;
        mat_addr_d  = mat_addr_q;
        mat_wdata_d = mat_wdata_q;
        prob_vld_d  = prob_vld_q;
        case (state_q)
            S_INIT: begin
                if (accept) begin
                    maxsize_d  = i_indata[15:0];
                    init_vld_d = 1'b1;
                    prob_id_d  = '0;
                    state_d    = S_NVERTS;
                end
            end
            S_NVERTS: begin
                if (accept) begin
                    nverts_d = i_indata[MAX_VERTSBITS-1:0];
                    last_d   = i_indata[31];
                    if (|i_indata[30:MAX_VERTSBITS]) begin
                        overflow_d = 1'b1;
                    end
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                n_words_d  = n_words_calc;
                word_cnt_d = '0;
                state_d    = (n_words_calc != '0) ? S_MATRIX : S_HOLD;
            end
            S_MATRIX: begin
                if (accept) begin
                    mat_we_d    = 1'b1;
                    mat_addr_d  = word_cnt_q;
                    mat_wdata_d = i_indata;
                    word_cnt_d  = word_cnt_q + AW'(1);
                    if (NW'(word_cnt_q) + NW'(1) == n_words_q) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // Valid lags hold entry by a cycle; accept only counts once valid is visible.
                prob_vld_d = 1'b1;
                if (prob_vld_q && i_prob_accept) begin
                    prob_vld_d = 1'b0;
                    if (last_q) begin
                        state_d = S_INIT;
                    end else begin
                        prob_id_d = prob_id_q + 16'd1;
                        state_d   = S_NVERTS;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge i_clk150 or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_INIT;
            maxsize_q   <= '0;
            init_vld_q  <= 1'b0;
            nverts_q    <= '0;
            last_q      <= 1'b0;
            prob_id_q   <= '0;
            overflow_q  <= 1'b0;
            n_words_q   <= '0;
            word_cnt_q  <= '0;
            mat_we_q    <= 1'b0;
            mat_addr_q  <= '0;
            mat_wdata_q <= '0;
            prob_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            maxsize_q   <= maxsize_d;
            init_vld_q  <= init_vld_d;
            nverts_q    <= nverts_d;
            last_q      <= last_d;
            prob_id_q   <= prob_id_d;
            overflow_q  <= overflow_d;
            n_words_q   <= n_words_d;
            word_cnt_q  <= word_cnt_d;
            mat_we_q    <= mat_we_d;
            mat_addr_q  <= mat_addr_d;
            mat_wdata_q <= mat_wdata_d;
            prob_vld_q  <= prob_vld_d;
        end
    end

    assign o_init_maxsize = maxsize_q;
    assign o_init_valid   = init_vld_q;
    assign o_mat_we       = mat_we_q;
    assign o_mat_addr     = mat_addr_q;
    assign o_mat_wdata    = mat_wdata_q;
    assign o_prob_valid   = prob_vld_q;
    assign o_prob_nverts  = nverts_q;
    assign o_prob_last    = last_q;
    assign o_prob_id      = prob_id_q;
    assign o_overflow     = overflow_q;
endmodule

// File: tb/tb_mmm_in_parser.sv
// Directed bench for mmm_in_parser with hand-computed expectations.
module tb_mmm_in_parser;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] indata;
    logic        have;
    logic        want;
    logic [15:0] init_maxsize;
    logic        init_valid;
    logic        mat_we;
    logic [7:0]  mat_addr;
    logic [31:0] mat_wdata;
    logic        prob_valid;
    logic        prob_accept;
    logic [5:0]  prob_nverts;
    logic        prob_last;
    logic [15:0] prob_id;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wr_adr[$];
    logic [31:0] wr_dat[$];

    mmm_in_parser #(.MAX_VERTSBITS(6)) dut (
        .i_clk150      (clk),
        .i_reset       (rst),
        .i_indata      (indata),
        .i_indata_have (have),
        .o_indata_want (want),
        .o_init_maxsize(init_maxsize),
        .o_init_valid  (init_valid),
        .o_mat_we      (mat_we),
        .o_mat_addr    (mat_addr),
        .o_mat_wdata   (mat_wdata),
        .o_prob_valid  (prob_valid),
        .i_prob_accept (prob_accept),
        .o_prob_nverts (prob_nverts),
        .o_prob_last   (prob_last),
        .o_prob_id     (prob_id),
        .o_overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mat_we) begin
            wr_adr.push_back(mat_addr);
            wr_dat.push_back(mat_wdata);
        end
    end

    // Drive one word; returns 1ns after the edge that accepted it.
    task automatic send_word(input logic [31:0] w, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            have = 1'b0;
        end
        @(negedge clk);
        have   = 1'b1;
        indata = w;
        t = 0;
        while (!want && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!want) begin
            checks++; errors++;
            $display("FAIL send_word timeout: want=%0b required 1 for word %h", want, w);
            have = 1'b0;
        end else begin
            @(posedge clk);
            #1 have = 1'b0;
        end
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (!prob_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!prob_valid) begin
            checks++; errors++;
            $display("FAIL %s valid timeout: prob_valid=%0b required 1", name, prob_valid);
        end
    endtask

    task automatic accept_hdr();
        @(negedge clk);
        prob_accept = 1'b1;
        @(posedge clk);
        #1 prob_accept = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; have = 1'b0; indata = '0; prob_accept = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (want !== 1'b1) begin errors++; $display("FAIL reset_want got=%b exp=1", want); end
        checks++; if ({init_valid, mat_we, prob_valid, overflow, prob_last} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000", {init_valid, mat_we, prob_valid, overflow, prob_last});
        end
        checks++; if ({init_maxsize, mat_addr, mat_wdata, prob_nverts, prob_id} !== '0) begin
            errors++; $display("FAIL reset_buses got=%h exp=0", {init_maxsize, mat_addr, mat_wdata, prob_nverts, prob_id});
        end
        rst = 1'b0;
    endtask

    task automatic test_normal();
        wr_adr.delete(); wr_dat.delete();
        send_word(32'd5, 0);
        @(negedge clk);
        checks++; if (init_valid !== 1'b1 || init_maxsize !== 16'd5) begin
            errors++; $display("FAIL init_pulse got valid=%b size=%0d exp valid=1 size=5", init_valid, init_maxsize);
        end
        @(negedge clk);
        checks++; if (init_valid !== 1'b0) begin errors++; $display("FAIL init_one_cycle got=%b exp=0", init_valid); end
        send_word(32'd4, 0);
        send_word(32'hDEADBEEF, 0);
        @(negedge clk);
        checks++; if (mat_we !== 1'b1 || mat_addr !== 8'd0 || mat_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL normal_write got we=%b addr=%0d data=%h exp 1 0 deadbeef", mat_we, mat_addr, mat_wdata);
        end
        checks++; if (prob_valid !== 1'b0) begin errors++; $display("FAIL normal_valid_early got=%b exp=0", prob_valid); end
        @(negedge clk);
        checks++; if (prob_valid !== 1'b1 || mat_we !== 1'b0) begin
            errors++; $display("FAIL normal_valid_edge got valid=%b we=%b exp 1 0", prob_valid, mat_we);
        end
        checks++; if (prob_nverts !== 6'd4 || prob_last !== 1'b0 || prob_id !== 16'd0) begin
            errors++; $display("FAIL normal_hdr got n=%0d last=%b id=%0d exp 4 0 0", prob_nverts, prob_last, prob_id);
        end
        checks++; if (wr_adr.size() !== 1) begin errors++; $display("FAIL normal_wr_count got=%0d exp=1", wr_adr.size()); end
        accept_hdr();
        checks++; if (prob_valid !== 1'b0 || want !== 1'b1) begin
            errors++; $display("FAIL normal_after_accept got valid=%b want=%b exp 0 1", prob_valid, want);
        end
    endtask

    task automatic test_last();
        wr_adr.delete(); wr_dat.delete();
        send_word(32'h8000_0021, 0);
        @(negedge clk);
        checks++; if (init_valid !== 1'b0) begin errors++; $display("FAIL last_not_init got=%b exp=0", init_valid); end
        for (int i = 0; i < 35; i++) send_word(32'hA500_0000 + i, 0);
        wait_valid("last");
        checks++; if (wr_adr.size() !== 35) begin errors++; $display("FAIL last_wr_count got=%0d exp=35", wr_adr.size()); end
        for (int i = 0; i < 35 && i < wr_adr.size(); i++) begin
            checks++;
            if (wr_adr[i] !== 8'(i) || wr_dat[i] !== 32'hA500_0000 + i) begin
                errors++; $display("FAIL last_wr[%0d] got addr=%0d data=%h exp %0d %h", i, wr_adr[i], wr_dat[i], i, 32'hA500_0000 + i);
            end
        end
        checks++; if (prob_last !== 1'b1 || prob_nverts !== 6'd33 || prob_id !== 16'd1) begin
            errors++; $display("FAIL last_hdr got last=%b n=%0d id=%0d exp 1 33 1", prob_last, prob_nverts, prob_id);
        end
        accept_hdr();
        checks++; if (want !== 1'b1) begin errors++; $display("FAIL last_want got=%b exp=1", want); end
        send_word(32'd7, 0);
        @(negedge clk);
        checks++; if (init_valid !== 1'b1 || init_maxsize !== 16'd7) begin
            errors++; $display("FAIL last_new_set got valid=%b size=%0d exp 1 7", init_valid, init_maxsize);
        end
    endtask

    task automatic test_zero();
        wr_adr.delete(); wr_dat.delete();
        send_word(32'd0, 0);
        @(negedge clk);
        checks++; if (prob_valid !== 1'b0 || want !== 1'b0) begin
            errors++; $display("FAIL zero_calc got valid=%b want=%b exp 0 0", prob_valid, want);
        end
        @(negedge clk);
        checks++; if (prob_valid !== 1'b0) begin errors++; $display("FAIL zero_valid_early got=%b exp=0", prob_valid); end
        @(negedge clk);
        checks++; if (prob_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got=%b exp=1", prob_valid); end
        checks++; if (prob_nverts !== 6'd0 || prob_id !== 16'd0 || prob_last !== 1'b0) begin
            errors++; $display("FAIL zero_hdr got n=%0d id=%0d last=%b exp 0 0 0", prob_nverts, prob_id, prob_last);
        end
        checks++; if (wr_adr.size() !== 0) begin errors++; $display("FAIL zero_no_write got=%0d exp=0", wr_adr.size()); end
        accept_hdr();
    endtask

    task automatic test_overflow();
        wr_adr.delete(); wr_dat.delete();
        send_word(32'h0000_0145, 0);
        @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        send_word(32'h1234_5678, 0);
        wait_valid("ovf");
        checks++; if (prob_nverts !== 6'd5 || prob_id !== 16'd1) begin
            errors++; $display("FAIL ovf_hdr got n=%0d id=%0d exp 5 1", prob_nverts, prob_id);
        end
        checks++; if (wr_adr.size() !== 1 || want !== 1'b0) begin
            errors++; $display("FAIL ovf_words got writes=%0d want=%b exp 1 0", wr_adr.size(), want);
        end
        accept_hdr();
    endtask

    task automatic test_backpressure();
        wr_adr.delete(); wr_dat.delete();
        send_word(32'd33, $urandom_range(0, 3));
        for (int i = 0; i < 35; i++) send_word(32'h1000_0000 + 3*i, $urandom_range(0, 3));
        wait_valid("bp");
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({want, prob_valid, prob_nverts, prob_last, prob_id} !== {1'b0, 1'b1, 6'd33, 1'b0, 16'd2}) begin
                errors++; $display("FAIL bp_hold[%0d] got want=%b valid=%b n=%0d last=%b id=%0d exp 0 1 33 0 2",
                                   c, want, prob_valid, prob_nverts, prob_last, prob_id);
            end
            @(negedge clk);
        end
        checks++; if (wr_adr.size() !== 35) begin errors++; $display("FAIL bp_wr_count got=%0d exp=35", wr_adr.size()); end
        for (int i = 0; i < 35 && i < wr_adr.size(); i++) begin
            checks++;
            if (wr_adr[i] !== 8'(i) || wr_dat[i] !== 32'h1000_0000 + 3*i) begin
                errors++; $display("FAIL bp_wr[%0d] got addr=%0d data=%h exp %0d %h", i, wr_adr[i], wr_dat[i], i, 32'h1000_0000 + 3*i);
            end
        end
        accept_hdr();
        checks++; if (prob_id !== 16'd3 || overflow !== 1'b1) begin
            errors++; $display("FAIL bp_after got id=%0d ovf=%b exp 3 1", prob_id, overflow);
        end
    endtask

    task automatic test_reset_mid();
        logic saw_valid;
        send_word(32'd33, 0);
        for (int i = 0; i < 10; i++) send_word(32'hC000_0000 + i, 0);
        #1 rst = 1'b1;
        #1;
        checks++; if ({mat_we, prob_valid, init_valid, overflow, prob_last} !== 5'b0 || want !== 1'b1) begin
            errors++; $display("FAIL rstmid_flags got we/valid/init/ovf/last=%b want=%b exp 00000 1",
                               {mat_we, prob_valid, init_valid, overflow, prob_last}, want);
        end
        checks++; if ({mat_addr, mat_wdata, prob_nverts, prob_id, init_maxsize} !== '0) begin
            errors++; $display("FAIL rstmid_buses got=%h exp=0", {mat_addr, mat_wdata, prob_nverts, prob_id, init_maxsize});
        end
        @(negedge clk);
        rst = 1'b0;
        wr_adr.delete(); wr_dat.delete();
        send_word(32'd9, 0);
        @(negedge clk);
        checks++; if (init_valid !== 1'b1 || init_maxsize !== 16'd9) begin
            errors++; $display("FAIL rstmid_init got valid=%b size=%0d exp 1 9", init_valid, init_maxsize);
        end
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (prob_valid) saw_valid = 1'b1;
        end
        checks++; if (saw_valid !== 1'b0 || wr_adr.size() !== 0) begin
            errors++; $display("FAIL rstmid_no_hdr got valid_seen=%b writes=%0d exp 0 0", saw_valid, wr_adr.size());
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_last();
        test_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
